// File: rtl/mips_alu_pkg.sv
// Shared ALU encodings and FSM state type.
// The ALU control decode imports this package too, so the opcodes stay in one place.
package mips_alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_SHL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

    // mul is the only multi-cycle op; everything else completes in one edge.
    function automatic logic op_is_mul(input logic [2:0] op);
        return op == ALU_MUL;
    endfunction

    // Shift op 110 goes left when direction matches DIR_LEFT, otherwise right.
    function automatic logic shift_is_left(input logic dir);
        return dir != DIR_RIGHT;
    endfunction

endpackage

// File: rtl/mips_alu_seq_if.sv
// Request/response bundle between the control path and the execution ALU.
interface mips_alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             start;
    logic [2:0]       op_code_Sel;
    logic             direction;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output start, op_code_Sel, direction, a, b, shamt,
        input  busy, done, result, zero, overflow
    );

    modport slave (
        input  start, op_code_Sel, direction, a, b, shamt,
        output busy, done, result, zero, overflow
    );
endinterface

// File: rtl/mips_seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH clocks.
// done/prod are combinational on the final iteration so the parent can
// capture the product on the same edge the engine retires.
module mips_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt;
    logic             busy_q;

    // Accumulator after this iteration's conditional add.
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign prod    = acc_nxt;
    assign done    = busy_q && (cnt == LAST);
    assign busy    = busy_q;

    // Latch operands on go, then shift/accumulate for a fixed WIDTH edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (go) begin
            busy_q <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy_q) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) busy_q <= 1'b0;
        end
    end
endmodule

// File: rtl/mips_alu_seq.sv
// Execution-stage ALU: single-cycle ops plus an iterative mul behind a
// start/busy/done handshake. All outputs except zero are registered.
module mips_alu_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic           clk,
    input  logic           rst,
    mips_alu_seq_if.slave  bus
);
    alu_state_t       state;
    alu_state_t       state_nxt;
    logic             load_alu;
    logic             load_mul;
    logic             mul_go;
    logic             mul_busy;
    logic             mul_last;
    logic [WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;
    logic             done_q;

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;
    assign sh   = bus.shamt;

    // Single-cycle datapath; overflow only meaningful for add/sub.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op_code_Sel)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_AND: alu_res = bus.a & bus.b;
            ALU_OR:  alu_res = bus.a | bus.b;
            ALU_NOR: alu_res = ~(bus.a | bus.b);
            ALU_SHL: alu_res = shift_is_left(bus.direction) ? (bus.b << sh) : (bus.b >> sh);
            ALU_SRA: alu_res = $unsigned($signed(bus.b) >>> sh);
            default: alu_res = '0;  // mul result comes from the engine
        endcase
    end

    mips_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .go   (mul_go),
        .a    (bus.a),
        .b    (bus.b),
        .busy (mul_busy),
        .done (mul_last),
        .prod (mul_prod)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and load strobes; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_go    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (op_is_mul(bus.op_code_Sel)) begin
                        mul_go    = 1'b1;
                        state_nxt = MUL;
                    end else begin
                        load_alu = 1'b1;
                    end
                end
            end
            MUL: begin
                if (mul_last) begin
                    load_mul  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result/overflow/done registers; result only moves on a completion edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load_alu) begin
                result_q <= alu_res;
                ovf_q    <= alu_ovf;
                done_q   <= 1'b1;
            end else if (load_mul) begin
                result_q <= mul_prod;
                ovf_q    <= 1'b0;
                done_q   <= 1'b1;
            end
        end
    end

    assign bus.busy     = mul_busy;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = (result_q == '0);
endmodule

// File: tb/tb_mips_alu_seq.sv
// Randomized and directed checks of mips_alu_seq against a plain-arithmetic model.
module tb_mips_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    logic [31:0] model_res = 32'h0;

    always #5 clk = ~clk;

    mips_alu_seq_if #(.WIDTH(32)) bus ();

    mips_alu_seq #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: arithmetic on wide integers, overflow from range check.
    function automatic void model(input logic [2:0] op, input logic dir,
                                  input logic [31:0] x, input logic [31:0] y,
                                  input logic [4:0] sh,
                                  output logic [31:0] r, output logic v);
        longint sx, sy, s;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        r = 32'h0;
        v = 1'b0;
        case (op)
            3'd0: begin s = sx + sy; r = x + y; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd1: begin s = sx - sy; r = x - y; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd2: begin p = {32'h0, x} * {32'h0, y}; r = p[31:0]; end
            3'd3: r = x & y;
            3'd4: r = x | y;
            3'd5: r = ~(x | y);
            3'd6: r = dir ? (y << sh) : (y >> sh);
            default: r = (y >> sh) | (y[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
        endcase
    endfunction

    task automatic drive(input logic s, input logic [2:0] op, input logic d,
                         input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
        bus.start       = s;
        bus.op_code_Sel = op;
        bus.direction   = d;
        bus.a           = x;
        bus.b           = y;
        bus.shamt       = sh;
    endtask

    task automatic test_reset();
        nvec++; if (bus.result !== 32'h0) begin nerr++; $display("FAIL reset_result: got %h want 0", bus.result); end
        nvec++; if (bus.zero !== 1'b1) begin nerr++; $display("FAIL reset_zero: got %b want 1", bus.zero); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", bus.done); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
        // load a nonzero overflowing result, then reset mid-run for 2 cycles
        drive(1, 3'd0, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        @(negedge clk);
        bus.start = 1'b0;
        nvec++; if (bus.result !== 32'hFFFF_FFFE) begin nerr++; $display("FAIL reset_preload: got %h want fffffffe", bus.result); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_res = 32'h0;
        nvec++; if (bus.result !== 32'h0) begin nerr++; $display("FAIL rerst_result: got %h want 0", bus.result); end
        nvec++; if (bus.zero !== 1'b1) begin nerr++; $display("FAIL rerst_zero: got %b want 1", bus.zero); end
        nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL rerst_ovf: got %b want 0", bus.overflow); end
        nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL rerst_done: got %b want 0", bus.done); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL rerst_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_addsub();
        logic [2:0]  op [5] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd1};
        logic [31:0] xa [5] = '{32'h7FFF_FFFF, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        logic [31:0] xb [5] = '{32'h1, 32'd5, 32'h1, 32'h1, 32'h8000_0000};
        logic [31:0] er [5] = '{32'h8000_0000, 32'h0, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000};
        logic        ev [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(1, op[i], 0, xa[i], xb[i], 0);
            @(negedge clk);
            bus.start = 1'b0;
            nvec++; if (bus.done !== 1'b1) begin nerr++; $display("FAIL addsub_done[%0d]: got %b want 1", i, bus.done); end
            nvec++; if (bus.result !== er[i]) begin nerr++; $display("FAIL addsub_result[%0d]: got %h want %h", i, bus.result, er[i]); end
            nvec++; if (bus.overflow !== ev[i]) begin nerr++; $display("FAIL addsub_ovf[%0d]: got %b want %b", i, bus.overflow, ev[i]); end
            nvec++; if (bus.zero !== (er[i] == 32'h0)) begin nerr++; $display("FAIL addsub_zero[%0d]: got %b", i, bus.zero); end
            nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL addsub_busy[%0d]: got %b want 0", i, bus.busy); end
            model_res = er[i];
            @(negedge clk);
            nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL addsub_pulse[%0d]: got %b want 0", i, bus.done); end
            nvec++; if (bus.result !== model_res) begin nerr++; $display("FAIL addsub_hold[%0d]: got %h want %h", i, bus.result, model_res); end
        end
    endtask

    task automatic test_logic_shift();
        logic [2:0]  op [9] = '{3'd3, 3'd5, 3'd4, 3'd6, 3'd6, 3'd7, 3'd6, 3'd6, 3'd7};
        logic        dr [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0]  sh [9] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0};
        logic [31:0] er [9] = '{32'h8000_0010, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0100,
                                32'h0800_0001, 32'hF800_0001, 32'h8000_0010, 32'h8000_0010, 32'h8000_0010};
        for (int i = 0; i < 9; i++) begin
            drive(1, op[i], dr[i], 32'hF0F0_F0F0, 32'h8000_0010, sh[i]);
            @(negedge clk);
            bus.start = 1'b0;
            nvec++; if (bus.done !== 1'b1) begin nerr++; $display("FAIL logic_done[%0d]: got %b want 1", i, bus.done); end
            nvec++; if (bus.result !== er[i]) begin nerr++; $display("FAIL logic_result[%0d]: got %h want %h", i, bus.result, er[i]); end
            nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL logic_ovf[%0d]: got %b want 0", i, bus.overflow); end
            model_res = er[i];
            @(negedge clk);
        end
    endtask

    task automatic test_random_ops();
        logic [2:0]  ops [7] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [2:0]  op;
        logic        d, ev;
        logic [31:0] x, y, er;
        logic [4:0]  sh;
        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 6)];
            d  = 1'($urandom_range(0, 1));
            x  = $urandom;
            y  = $urandom;
            case ($urandom_range(0, 3))
                0: sh = 5'd0;
                1: sh = 5'd31;
                default: sh = 5'($urandom_range(0, 31));
            endcase
            if (i % 9 == 0) y = x;  // exercise zero / equal operands
            model(op, d, x, y, sh, er, ev);
            drive(1, op, d, x, y, sh);
            @(negedge clk);
            bus.start = 1'b0;
            nvec++; if (bus.done !== 1'b1) begin nerr++; $display("FAIL rand_done[%0d] op%0d: got %b want 1", i, op, bus.done); end
            nvec++; if (bus.result !== er) begin nerr++; $display("FAIL rand_result[%0d] op%0d: got %h want %h", i, op, bus.result, er); end
            nvec++; if (bus.overflow !== ev) begin nerr++; $display("FAIL rand_ovf[%0d] op%0d: got %b want %b", i, op, bus.overflow, ev); end
            nvec++; if (bus.zero !== (er == 32'h0)) begin nerr++; $display("FAIL rand_zero[%0d]: got %b", i, bus.zero); end
            model_res = er;
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [31:0] xs [6];
        logic [31:0] ys [6];
        logic [31:0] er;
        logic        ev;
        int          first, pulses;
        xs[0] = 32'h0001_2345; ys[0] = 32'h0000_0100;
        xs[1] = 32'hFFFF_FFFF; ys[1] = 32'hFFFF_FFFF;
        xs[2] = 32'h0;         ys[2] = 32'h1234_5678;
        for (int i = 3; i < 6; i++) begin xs[i] = $urandom; ys[i] = $urandom; end
        for (int i = 0; i < 6; i++) begin
            model(3'd2, 0, xs[i], ys[i], 0, er, ev);
            drive(1, 3'd2, 0, xs[i], ys[i], 0);
            first  = -1;
            pulses = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clk);
                if (bus.done === 1'b1) begin pulses++; if (first < 0) first = k; end
                if (k <= 32) begin
                    nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL mul_busy[%0d] k=%0d: got %b want 1", i, k, bus.busy); end
                    nvec++; if (bus.result !== model_res) begin nerr++; $display("FAIL mul_hold[%0d] k=%0d: got %h want %h", i, k, bus.result, model_res); end
                end
                if (k == 33) begin
                    nvec++; if (bus.result !== er) begin nerr++; $display("FAIL mul_result[%0d]: got %h want %h", i, bus.result, er); end
                    nvec++; if (bus.overflow !== 1'b0) begin nerr++; $display("FAIL mul_ovf[%0d]: got %b want 0", i, bus.overflow); end
                    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL mul_busy_end[%0d]: got %b want 0", i, bus.busy); end
                    model_res = er;
                end
                // inputs for the next cycle; the poke is a start while busy
                bus.start = 1'b0;
                if (i == 0 && k == 5) drive(1, 3'd0, 0, 32'd1, 32'd2, 0);
                if (i == 1 && k == 20) drive(1, 3'd2, 0, 32'd3, 32'd3, 0);
            end
            nvec++; if (first !== 33) begin nerr++; $display("FAIL mul_latency[%0d]: got %0d want 33", i, first); end
            nvec++; if (pulses !== 1) begin nerr++; $display("FAIL mul_pulses[%0d]: got %0d want 1", i, pulses); end
        end
    endtask

    task automatic test_reset_mid_mul();
        int pulses = 0;
        drive(1, 3'd2, 0, 32'h0000_1234, 32'h0000_0011, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_res = 32'h0;
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        nvec++; if (bus.result !== 32'h0) begin nerr++; $display("FAIL midrst_result: got %h want 0", bus.result); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) pulses++;
        end
        nvec++; if (pulses !== 0) begin nerr++; $display("FAIL midrst_quiet: got %0d active cycles want 0", pulses); end
        drive(1, 3'd0, 0, 32'd3, 32'd4, 0);
        @(negedge clk);
        bus.start = 1'b0;
        nvec++; if (bus.done !== 1'b1) begin nerr++; $display("FAIL midrst_add_done: got %b want 1", bus.done); end
        nvec++; if (bus.result !== 32'd7) begin nerr++; $display("FAIL midrst_add_result: got %h want 7", bus.result); end
        model_res = 32'd7;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  op [3] = '{3'd0, 3'd1, 3'd4};
        logic [31:0] xs [3];
        logic [31:0] ys [3];
        logic [31:0] er [3];
        logic [31:0] emul;
        logic        ev;
        int          first = -1;
        for (int i = 0; i < 3; i++) begin
            xs[i] = $urandom; ys[i] = $urandom;
            model(op[i], 0, xs[i], ys[i], 0, er[i], ev);
        end
        model(3'd2, 0, 32'h0000_ABCD, 32'h0001_0003, 0, emul, ev);
        drive(1, op[0], 0, xs[0], ys[0], 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++; if (bus.done !== 1'b1) begin nerr++; $display("FAIL b2b_done[%0d]: got %b want 1", i, bus.done); end
            nvec++; if (bus.result !== er[i]) begin nerr++; $display("FAIL b2b_result[%0d]: got %h want %h", i, bus.result, er[i]); end
            model_res = er[i];
            if (i < 2) drive(1, op[i+1], 0, xs[i+1], ys[i+1], 0);
            else       drive(1, 3'd2, 0, 32'h0000_ABCD, 32'h0001_0003, 0);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (k == 1) begin
                nvec++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL b2b_mul_accept: got busy %b want 1", bus.busy); end
            end
            if (bus.done === 1'b1 && first < 0) first = k;
        end
        nvec++; if (first !== 33) begin nerr++; $display("FAIL b2b_mul_latency: got %0d want 33", first); end
        nvec++; if (bus.result !== emul) begin nerr++; $display("FAIL b2b_mul_result: got %h want %h", bus.result, emul); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 3'd0, 0, 32'h0, 32'h0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_addsub();
        test_logic_shift();
        test_random_ops();
        test_mul();
        test_reset_mid_mul();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mips_alu_seq.md
Name: mips_alu_seq

Overview:
- Execution-stage ALU that sits directly downstream of the ALU control decode and consumes its 3-bit operation select and shift direction.
- Single-cycle ops (add, sub, and, or, nor, shifts) complete with one registered cycle of latency.
- mul runs on an iterative shift-add engine over WIDTH cycles.
- A start/busy/done handshake lets the control path stall the pipeline during mul.

Parameters:
- WIDTH, 32: operand and result width.
- SHW, $clog2(WIDTH): shift-amount width (5 at default).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op_code_Sel  in  3  operation select (encoding under Behaviour).
- direction  in  1  for op 110 only: 1=left, 0=right; ignored for all other ops.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt or immediate); this is the shifted operand.
- shamt  in  SHW  shift amount.
- busy  out  1  high while a mul is iterating.
- done  out  1  one-cycle pulse; result is valid from this cycle.
- result  out  WIDTH  registered result; holds until the next completion.
- zero  out  1  combinational (result == 0).
- overflow  out  1  registered signed overflow, add/sub only.

Behaviour:
- One clock, clk; reset is synchronous and active-high on rst.
- Reset: state=IDLE, busy=0, done=0, result=0, overflow=0, hence zero=1. Reset overrides everything, including an in-flight mul; no done is produced for the aborted op.
- Encoding:
  - 000 add: a+b
  - 001 sub: a-b
  - 010 mul: low WIDTH bits of a*b, unsigned shift-add; the low word is identical for signed operands
  - 011 and
  - 100 or
  - 101 nor
  - 110 logical shift of b by shamt: sll if direction=1, srl if direction=0
  - 111 sra: b >>> shamt, sign-filled
- All arithmetic wraps modulo 2^WIDTH.
- overflow is computed only for add/sub:
  - add: sign(a)==sign(b) and sign(sum)!=sign(a)
  - sub: sign(a)!=sign(b) and sign(diff)!=sign(a)
  - forced to 0 for every other op.
- FSM has two states, IDLE and MUL.
- IDLE, start=1, op != 010: at that edge, result and overflow are loaded and done=1 for exactly the next cycle. Latency is 1 and busy stays 0.
- IDLE, start=1, op=010: at that edge, a→multiplicand, b→multiplier, acc=0, cnt=0, busy=1, state=MUL. done stays 0.
- MUL: each edge does the following:
  - if multiplier[0], acc += multiplicand
  - multiplicand <<= 1; multiplier >>= 1; cnt++
- MUL exit: on the edge where cnt==WIDTH-1, acc' → result, overflow=0, done=1, busy=0, state=IDLE.
- mul latency: done is high in the cycle following the (WIDTH+1)th edge counted from the start edge, i.e. 33 cycles at default.
- No early termination: latency is fixed and independent of operand values.
- start while busy=1 is ignored, with no queueing. Operand changes during MUL have no effect because the operands were latched at start.
- Back-to-back: start may be high in the same cycle as done. In IDLE the new op is accepted, so single-cycle ops sustain one result per cycle.
- done is never high for two consecutive cycles unless start is held high for consecutive non-mul ops.
- shamt=0 returns b unchanged for all shifts. shamt=WIDTH-1 is the maximum; SHW bits cannot encode larger values.
- result is unchanged except on a completion edge or on reset.

Decomposition:
- Shared package mips_alu_pkg holds:
  - localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_MUL=3'b010, ALU_AND=3'b011, ALU_OR=3'b100, ALU_NOR=3'b101, ALU_SHL=3'b110, ALU_SRA=3'b111
  - DIR_LEFT=1'b1, DIR_RIGHT=1'b0
  - state enum alu_state_t {IDLE, MUL}
- The same package is imported by the ALU control decode.
- One sub-module, mips_seq_mul: the iterative shift-add engine.
  - Inputs: clk, rst, go, a, b.
  - Outputs: busy, done, prod.
- mips_alu_seq instantiates mips_seq_mul and muxes its product with the combinational datapath into the result register.

Test Plan:
- Reset: assert rst 2 cycles mid-run → result=0, zero=1, busy=0, done=0, overflow=0.
- add/sub overflow:
  - add 0x7FFFFFFF+1 → result=0x80000000, overflow=1, done 1 cycle after start.
  - sub 5-5 → result=0, zero=1, overflow=0.
- Logic and shifts with a=0xF0F0F0F0, b=0x80000010:
  - and=0x80000010, nor=0x0F0F0F0F
  - sll shamt=4 → 0x00000100
  - srl shamt=4 → 0x08000001
  - sra shamt=4 → 0xF8000001
  - shamt=0 returns b unchanged.
- mul: 0x00012345 × 0x00000100 → 0x01234500, done exactly 33 cycles after start.
  - 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
  - busy=1 throughout; a second start mid-mul is ignored and produces no extra done.
- Reset mid-mul at cycle 10 → no done pulse, state IDLE. A following add 3+4 → 7 with latency 1.
- Back-to-back: start held for add, sub, or on consecutive cycles → three consecutive done pulses with correct results. Then a mul issued on the same cycle as the last done is accepted.
